// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data load/store,
// with data priority bounded by a fetch-starvation limit. Optional perf counters: MEM_ARB_PERF_EN.
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_done,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [3:0]      d_be,
   output logic            d_done,
   output logic [XLEN-1:0] d_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_be,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            stall_if,
   output logic            stall_mem
`ifdef MEM_ARB_PERF_EN
  ,output logic [XLEN-1:0] perf_i_grants,
   output logic [XLEN-1:0] perf_d_grants,
   output logic [XLEN-1:0] perf_conflicts
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e          state_q;
   logic [3:0]      starve_cnt_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic            we_q;
   logic [3:0]      be_q;

   logic idle;
   logic grant_i;
   logic grant_d;
   logic ack_i;
   logic ack_d;

   assign idle    = (state_q == IDLE);
   // Data wins a tie unless fetch has already waited through LIMIT data grants.
   assign grant_d = idle & d_req & (~i_req | (starve_cnt_q != LIMIT));
   assign grant_i = idle & i_req & ~grant_d;
   assign ack_i   = (state_q == BUSY_I) & mem_ack;
   assign ack_d   = (state_q == BUSY_D) & mem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         be_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  state_q <= BUSY_D;
                  addr_q  <= d_addr;
                  wdata_q <= d_wdata;
                  we_q    <= d_we;
                  be_q    <= d_be;
                  if (i_req && (starve_cnt_q != LIMIT)) begin
                     starve_cnt_q <= starve_cnt_q + 4'd1;
                  end
               end else if (grant_i) begin
                  state_q      <= BUSY_I;
                  addr_q       <= i_addr;
                  wdata_q      <= '0;
                  we_q         <= 1'b0;
                  be_q         <= 4'b1111;
                  starve_cnt_q <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ack) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory side sees only latched payload, so it is stable for the whole access.
   assign mem_req   = ~idle;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

   assign i_done    = ack_i;
   assign d_done    = ack_d;
   assign i_rdata   = ack_i ? mem_rdata : '0;
   assign d_rdata   = ack_d ? mem_rdata : '0;
   assign stall_if  = rst_n & i_req & ~ack_i;
   assign stall_mem = rst_n & d_req & ~ack_d;

`ifdef MEM_ARB_PERF_EN
   logic [XLEN-1:0] perf_i_q;
   logic [XLEN-1:0] perf_d_q;
   logic [XLEN-1:0] perf_c_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_i_q <= '0;
         perf_d_q <= '0;
         perf_c_q <= '0;
      end else begin
         if (grant_i) perf_i_q <= perf_i_q + 1'b1;
         if (grant_d) perf_d_q <= perf_d_q + 1'b1;
         if (idle && i_req && d_req) perf_c_q <= perf_c_q + 1'b1;
      end
   end

   assign perf_i_grants  = perf_i_q;
   assign perf_d_grants  = perf_d_q;
   assign perf_conflicts = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
   localparam int XLEN  = 32;
   localparam int LIMIT = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            i_req = 1'b0;
   logic [31:0]     i_addr = '0;
   logic            i_done;
   logic [31:0]     i_rdata;
   logic            d_req = 1'b0;
   logic            d_we = 1'b0;
   logic [31:0]     d_addr = '0;
   logic [31:0]     d_wdata = '0;
   logic [3:0]      d_be = 4'hF;
   logic            d_done;
   logic [31:0]     d_rdata;
   logic            mem_req;
   logic            mem_we;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   logic [3:0]      mem_be;
   logic            mem_ack = 1'b0;
   logic [31:0]     mem_rdata = 32'hBAD0BAD0;
   logic            stall_if;
   logic            stall_mem;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]     perf_i_grants;
   logic [31:0]     perf_d_grants;
   logic [31:0]     perf_conflicts;
`endif

   mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARB_PERF_EN
     ,.perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_conflicts(perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic chks(input string nm, input string act, input string exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%s required=%s", nm, act, exp);
      end
   endtask

   // Memory contents as seen by the bench.
   function automatic logic [31:0] rd_of(input logic [31:0] a);
      if (a == 32'h10) return 32'h00500093;
      return a * 32'd3 + 32'h1234;
   endfunction

   // Memory responder: ack_dly cycles counting the first mem_req cycle as 1; 0 = never ack.
   int   ack_dly = 1;
   logic spur_ack = 1'b0;
   int   wcnt = 0;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         wcnt    = 0;
         mem_ack = 1'b0;
      end else if (mem_req) begin
         wcnt++;
         mem_ack = (ack_dly != 0) && (wcnt == ack_dly);
      end else begin
         wcnt    = 0;
         mem_ack = spur_ack;
      end
      mem_rdata = mem_ack ? rd_of(mem_addr) : 32'hBAD0BAD0;
   end

   // Reference model: one outstanding transaction, owner and payload recorded at grant.
   bit          m_busy = 0;
   bit          m_dat = 0;
   bit          m_we = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_be = '0;
   int          m_starve = 0;
   int          m_pi = 0;
   int          m_pd = 0;
   int          m_pc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy   <= 0;
         m_starve <= 0;
         m_pi     <= 0;
         m_pd     <= 0;
         m_pc     <= 0;
      end else if (!m_busy) begin
         if (i_req && d_req) m_pc <= m_pc + 1;
         if (d_req && !(i_req && m_starve == LIMIT)) begin
            m_busy  <= 1;
            m_dat   <= 1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_be;
            m_pd    <= m_pd + 1;
            if (i_req) m_starve <= (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
         end else if (i_req) begin
            m_busy   <= 1;
            m_dat    <= 0;
            m_we     <= 0;
            m_addr   <= i_addr;
            m_be     <= 4'hF;
            m_pi     <= m_pi + 1;
            m_starve <= 0;
         end
      end else if (mem_ack) begin
         m_busy <= 0;
      end
   end

   always @(negedge clk) begin
      bit ei, ed;
      ei = rst_n && m_busy && !m_dat && mem_ack;
      ed = rst_n && m_busy && m_dat && mem_ack;
      chk1("mem_req", mem_req, rst_n && m_busy);
      chk1("i_done", i_done, ei);
      chk1("d_done", d_done, ed);
      chk32("i_rdata", i_rdata, ei ? rd_of(m_addr) : 32'h0);
      chk32("d_rdata", d_rdata, ed ? rd_of(m_addr) : 32'h0);
      chk1("stall_if", stall_if, rst_n && i_req && !ei);
      chk1("stall_mem", stall_mem, rst_n && d_req && !ed);
      if (rst_n && m_busy) begin
         chk32("mem_addr", mem_addr, m_addr);
         chk1("mem_we", mem_we, m_we);
         chk32("mem_be", {28'h0, mem_be}, {28'h0, m_be});
         if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
      end
`ifdef MEM_ARB_PERF_EN
      chk32("perf_i", perf_i_grants, 32'(m_pi));
      chk32("perf_d", perf_d_grants, 32'(m_pd));
      chk32("perf_c", perf_conflicts, 32'(m_pc));
`endif
   end

   // Per-cycle sampling used by the directed scenarios.
   logic        s_i_done, s_d_done;
   logic [31:0] s_i_rdata, s_d_rdata, s_addr, s_wdata;
   logic        s_we;
   logic [3:0]  s_be;
   int          ni_done = 0, nd_done = 0, cyc = 0;
   string       dlog = "";

   task automatic step();
      @(negedge clk);
      s_i_done  = i_done;
      s_d_done  = d_done;
      s_i_rdata = i_rdata;
      s_d_rdata = d_rdata;
      s_addr    = mem_addr;
      s_wdata   = mem_wdata;
      s_we      = mem_we;
      s_be      = mem_be;
      if (i_done) begin ni_done++; dlog = {dlog, "I"}; end
      if (d_done) begin nd_done++; dlog = {dlog, "D"}; end
      @(posedge clk);
      #1;
   endtask

   // Runs until every active request has been served; d_repeat extra data dones keep d_req high.
   logic [31:0] l_i_rdata, l_d_rdata, l_addr, l_wdata;
   logic        l_we;
   logic [3:0]  l_be;
   task automatic run(input int max_cyc, input int d_repeat);
      int n, dd;
      n = 0;
      dd = 0;
      while ((i_req || d_req) && n < max_cyc) begin
         step();
         n++;
         if (s_i_done) begin
            l_i_rdata = s_i_rdata; l_addr = s_addr; l_we = s_we; l_be = s_be;
            i_req = 1'b0;
         end
         if (s_d_done) begin
            l_d_rdata = s_d_rdata; l_addr = s_addr; l_we = s_we; l_be = s_be; l_wdata = s_wdata;
            dd++;
            if (dd > d_repeat) d_req = 1'b0;
         end
      end
      cyc = n;
      if (i_req || d_req) begin
         chki("run_timeout", n, -1);
         i_req = 1'b0;
         d_req = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nd0;
      bit seen;
      // Reset state with requests asserted: stalls must stay low.
      i_req = 1'b1;
      d_req = 1'b1;
      #12;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_stall_if", stall_if, 1'b0);
      chk1("rst_stall_mem", stall_mem, 1'b0);
      chk1("rst_i_done", i_done, 1'b0);
      chk32("rst_d_rdata", d_rdata, 32'h0);
      i_req = 1'b0;
      d_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) step();

      // Fetch only, ack two cycles after mem_req.
      ack_dly = 3;
      i_addr = 32'h10;
      i_req = 1'b1;
      run(20, 0);
      chki("t1_latency", cyc, 4);
      chk32("t1_i_rdata", l_i_rdata, 32'h00500093);
      chk32("t1_mem_addr", l_addr, 32'h10);
      chk1("t1_mem_we", l_we, 1'b0);
      chk32("t1_mem_be", {28'h0, l_be}, 32'hF);

      // Spurious ack while idle must be ignored, then a single-cycle store.
      spur_ack = 1'b1;
      repeat (2) step();
      spur_ack = 1'b0;
      step();
      ni_done = 0;
      nd_done = 0;
      ack_dly = 1;
      d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
      d_req = 1'b1;
      run(20, 0);
      repeat (3) step();
      d_we = 1'b0; d_be = 4'hF;
      chki("t2_latency", cyc, 2);
      chk1("t2_mem_we", l_we, 1'b1);
      chk32("t2_mem_be", {28'h0, l_be}, 32'h3);
      chk32("t2_mem_wdata", l_wdata, 32'hDEADBEEF);
      chki("t2_d_done_cnt", nd_done, 1);
      chki("t2_i_done_cnt", ni_done, 0);

      // Simultaneous requests: data first, fetch after one idle bubble.
      ack_dly = 2;
      dlog = "";
      i_addr = 32'h14; d_addr = 32'h204;
      i_req = 1'b1; d_req = 1'b1;
      run(30, 0);
      chks("t3_order", dlog, "DI");
      chki("t3_cycles", cyc, 6);

      // Fetch held, data re-requested continuously: starvation limit forces fetch in.
      ack_dly = 1;
      dlog = "";
      i_addr = 32'h18; d_addr = 32'h208;
      i_req = 1'b1; d_req = 1'b1;
      run(60, 4);
      chks("t4_order", dlog, "DDDDID");

      // Reset during a data access with ack withheld.
      ack_dly = 0;
      d_addr = 32'h20C;
      d_req = 1'b1;
      step();
      step();
      chk1("t5_busy_before_rst", mem_req, 1'b1);
      nd0 = nd_done;
      rst_n = 1'b0;
      #1;
      chk1("t5_mem_req_dropped", mem_req, 1'b0);
      chk1("t5_no_d_done", d_done, 1'b0);
      d_req = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chki("t5_done_count", nd_done, nd0);
      ack_dly = 1;
      i_addr = 32'h40;
      i_req = 1'b1;
      run(20, 0);
      chki("t5_fetch_latency", cyc, 2);
      chk32("t5_fetch_rdata", l_i_rdata, 32'h000012F4);

      // Fetch, load abandoned by its requester mid-access, then one conflict.
      i_addr = 32'h20;
      i_req = 1'b1;
      run(20, 0);
      ack_dly = 3;
      d_addr = 32'h300;
      d_req = 1'b1;
      step();
      step();
      d_addr = 32'h999;
      d_req = 1'b0;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (s_d_done) begin
            seen = 1;
            l_d_rdata = s_d_rdata;
         end
      end
      chk1("t6_dropped_done", seen, 1'b1);
      chk32("t6_dropped_rdata", l_d_rdata, 32'h00001B34);
      ack_dly = 1;
      i_addr = 32'h24; d_addr = 32'h304;
      i_req = 1'b1; d_req = 1'b1;
      run(20, 0);
      step();
      chki("t6_model_fetch_grants", m_pi, 3);
      chki("t6_model_data_grants", m_pd, 2);
      chki("t6_model_conflicts", m_pc, 1);
`ifdef MEM_ARB_PERF_EN
      chk32("t6_perf_i", perf_i_grants, 32'd3);
      chk32("t6_perf_d", perf_d_grants, 32'd2);
      chk32("t6_perf_c", perf_conflicts, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
